mem_arbiter: RTL
================

# mem_arbiter

Sequences and shares the single-port data/instruction memory of the pipelined processor between the fetch stage (read-only) and the memory stage (read/write). Latches the winning request, holds the memory interface for a fixed access latency, returns read data to the owner with a one-cycle valid pulse, and generates the fetch and memory-stage stall signals. Sits between the pipeline's F/M stages and the memory array.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 2, memory access cycles (>=1)
- STARVE_MAX, 4, consecutive MEM grants allowed while IF waits (>=1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifReq  in  1  fetch read request
- ifAddr  in  ADDR_W  fetch address
- ifRdata  out  DATA_W  fetch read data
- ifValid  out  1  fetch completion pulse
- stallF  out  1  fetch stall
- memReq  in  1  memory-stage request (MemToRegM | MemWriteM)
- memWe  in  1  1 = write
- memAddr  in  ADDR_W  address (ALUOutM)
- memWdata  in  DATA_W  write data (writeDataM)
- memRdata  out  DATA_W  memory-stage read data
- memValid  out  1  memory-stage completion pulse
- stallM  out  1  memory-stage stall
- ramEn, ramWe  out  1  memory enable / write enable
- ramAddr  out  ADDR_W  memory address
- ramWdata  out  DATA_W  memory write data
- ramRdata  in  DATA_W  memory read data
- active  out  1  access in progress

## Operation

- FSM: IDLE, ACCESS, RESP.
- IDLE: if ifReq or memReq at the clock edge, arbitrate, latch owner/addr/we/wdata, load cycle counter LATENCY-1, go to ACCESS. Otherwise stay.
- ACCESS: ramEn=1, ramAddr/ramWdata/ramWe driven from latched registers, stable for exactly LATENCY cycles. On the last cycle (counter==0) edge, capture ramRdata into the owner's rdata register (reads only) and go to RESP.
- RESP: owner's valid=1 for one cycle, then go to IDLE.
- Arbitration: MEM wins by default. starveCnt counts MEM grants made while ifReq=1 and resets on any IF grant. When starveCnt==STARVE_MAX and ifReq=1, IF wins.
- ramWe is 1 only for MEM writes. IF never writes.
- On a write, memValid still pulses and memRdata is unchanged.
- ifRdata/memRdata hold their value until the next read completion for that port.
- stallF = ifReq & ~ifValid; stallM = memReq & ~memValid (combinational).
- active = (state != IDLE).
- Requester drops req mid-access: the access completes and valid still pulses. The requester ignores it.
- Requests arriving in ACCESS/RESP wait. They are arbitrated only in IDLE.

## Timing

- Reset values: state=IDLE, ramEn/ramWe=0, ramAddr/ramWdata=0, ifRdata/memRdata=0, ifValid/memValid=0, active=0, starveCnt=0. During reset stallF=ifReq and stallM=memReq.
- Reset mid-access aborts the access: ramEn drops asynchronously, no valid pulse, no data capture.
- Request sampled at edge ending cycle 0 → ACCESS cycles 1..LATENCY → valid in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- Stall stays high from the request cycle through the cycle before valid. It drops combinationally in the valid cycle.

## Test plan

- Reset: rst_n=0 with ifReq=memReq=1 → ramEn=0, active=0, valids=0, rdata=0, stallF=stallM=1. Release → MEM granted first.
- IF read, LATENCY=2: ifReq=1, ifAddr=0x4, ramRdata=0xDEADBEEF → ramEn cycles 1-2 with ramAddr=0x4, ifValid in cycle 3, ifRdata=0xDEADBEEF, stallF high cycles 0-2.
- MEM write: memReq=1, memWe=1, memAddr=0x1, memWdata=0x1 → ramWe=ramEn=1 cycles 1-2, ramAddr=0x1, ramWdata=0x1, memValid cycle 3, memRdata unchanged.
- Contention, STARVE_MAX=4, both reqs held high → grant order M,M,M,M,F,M,M,M,M,F, completions every 4 cycles.
- Reset asserted in ACCESS cycle 1 → ramEn=0 immediately, no valid pulse. After release, a new memReq read of 0x8 completes normally with memRdata=ramRdata.
- memReq dropped in ACCESS cycle 1 → memValid still pulses in cycle 3, and the next IF request is granted in the following IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (read-only) and memory stage (read/write)
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ifReq/ifAddr -> ifRdata/ifValid    fetch read port, stallF fetch stall
//   memReq/memWe/memAddr/memWdata      memory-stage request
//   memRdata/memValid, stallM          memory-stage response and stall
//   ramEn/ramWe/ramAddr/ramWdata       memory array drive, ramRdata read data
//   active                             an access or response is in progress
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifRdata,
  output logic              ifValid,
  output logic              stallF,
  input  logic              memReq,
  input  logic              memWe,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memWdata,
  output logic [DATA_W-1:0] memRdata,
  output logic              memValid,
  output logic              stallM,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata,
  output logic              active
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;
  logic r_owner_if, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_mem_rdata;
  logic w_req, w_if_win, w_done, w_grant;
  assign w_req    = ifReq | memReq;
  // MEM wins unless IF has been passed over STARVE_MAX times in a row
  assign w_if_win = ifReq & (~memReq | (r_starve == SW'(STARVE_MAX)));
  assign w_done   = (r_cnt == '0);
  assign w_grant  = (r_state == IDLE) & w_req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE)   ? (w_req ? ACCESS : IDLE) :
             (r_state == ACCESS) ? (w_done ? RESP : ACCESS) : IDLE;
  end
  always_comb begin
    ramEn    = (r_state == ACCESS);
    ramWe    = (r_state == ACCESS) & r_we;
    ifValid  = (r_state == RESP) & r_owner_if;
    memValid = (r_state == RESP) & ~r_owner_if;
    active   = (r_state != IDLE);
  end
  assign ramAddr  = r_addr;
  assign ramWdata = r_wdata;
  assign ifRdata  = r_if_rdata;
  assign memRdata = r_mem_rdata;
  assign stallF   = ifReq & ~ifValid;
  assign stallM   = memReq & ~memValid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_if  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner_if <= w_if_win;
        r_we       <= ~w_if_win & memWe;
        r_addr     <= w_if_win ? ifAddr : memAddr;
        r_wdata    <= w_if_win ? '0 : memWdata;
        r_cnt      <= CW'(LATENCY - 1);
        // only MEM grants that overtake a waiting fetch count toward starvation
        r_starve   <= w_if_win ? '0 : ifReq ? r_starve + 1'b1 : r_starve;
      end
      if (r_state == ACCESS) begin
        if (!w_done) r_cnt <= r_cnt - 1'b1;
        if (w_done && !r_we && r_owner_if)  r_if_rdata  <= ramRdata;
        if (w_done && !r_we && !r_owner_if) r_mem_rdata <= ramRdata;
      end
    end
  end
endmodule
